disp_ram: RTL

DISP_RAM -- requirements
Module: disp_ram

---
 rtl/disp_ram_pkg.sv | 7 +
 rtl/disp_ram_mem.sv | 27 ++
 rtl/disp_ram.sv | 77 +++++++
 3 files changed

// File: rtl/disp_ram_pkg.sv
// disp_ram_pkg: shared FSM state type and default geometry for the dispatch RAM
package disp_ram_pkg;
    localparam int AW_DEF = 11;
    localparam int DW_DEF = 17;
    localparam int MW_DEF = 7;
    typedef enum logic {INIT, RUN} state_e;
endpackage

// File: rtl/disp_ram_mem.sv
// disp_ram_mem: simple dual-port array, one write port, one registered read port with enable
// ports: clk, reset (clears only the read register), we/waddr/wdata, re/raddr, rdata
module disp_ram_mem
    import disp_ram_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int W  = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [2**AW];
    logic [W-1:0] rdata_q, rdata_d;
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    always_comb rdata_d = re ? mem[raddr] : rdata_q;
    always_ff @(posedge clk or posedge reset)
        if (reset) rdata_q <= '0;
        else rdata_q <= rdata_d;
    assign rdata = rdata_q;
endmodule

// File: rtl/disp_ram.sv
// disp_ram: dispatch RAM with self-clearing INIT/RUN sequencer and optional parity (DISP_RAM_PARITY_EN)
// inputs : clk, reset (async, active high), state_prefetch, state_write, dispwr, clr,
//          ir_disp = {ir[22:13], ir[12], ir[9], ir[8]}, vmo_map = {vmo[19], vmo[18]}, r, dmask, a
// outputs: {dr, dp, dn, dpc} registered read word, busy (clear in progress), par_err
module disp_ram
    import disp_ram_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int MW = MW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          state_prefetch,
    input  logic          state_write,
    input  logic [AW+1:0] ir_disp,
    input  logic [1:0]    vmo_map,
    input  logic [MW-1:0] r,
    input  logic [MW-1:0] dmask,
    input  logic [DW-1:0] a,
    input  logic          dispwr,
    input  logic          clr,
    output logic [DW-4:0] dpc,
    output logic          dn,
    output logic          dp,
    output logic          dr,
    output logic          busy,
    output logic          par_err
);
`ifdef DISP_RAM_PARITY_EN
    localparam int MEMW = DW + 1;
`else
    localparam int MEMW = DW;
`endif
    state_e state_q, state_d;
    logic [AW-1:0] ctr_q, ctr_d, dadr, waddr;
    logic daddr0, dwe, rd_en, we;
    logic [MEMW-1:0] wdata, rdata;
    always_comb begin
        busy    = state_q == INIT;
        daddr0  = (ir_disp[0] & vmo_map[0]) | (ir_disp[1] & vmo_map[1]) | (dmask[0] & r[0]) | ir_disp[2];
        dadr    = {ir_disp[AW+1:3], daddr0} | AW'({dmask[MW-1:1] & r[MW-1:1], 1'b0});
        dwe     = dispwr & state_write & ~busy;
        rd_en   = ~state_prefetch & ~dwe & ~busy;
        we      = busy | dwe;
        waddr   = busy ? ctr_q : dadr;
        state_d = busy ? (&ctr_q ? RUN : INIT) : (clr ? INIT : RUN);
        ctr_d   = busy ? ctr_q + AW'(1) : '0;
    end
`ifdef DISP_RAM_PARITY_EN
    // stored bit makes each word even parity, so any odd flip shows as ^rdata == 1
    assign wdata   = busy ? '0 : {^a, a};
    assign par_err = ^rdata;
`else
    assign wdata   = busy ? '0 : a;
    assign par_err = 1'b0;
`endif
    assign {dr, dp, dn, dpc} = rdata[DW-1:0];
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= INIT;
            ctr_q   <= '0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
        end
    disp_ram_mem #(.AW(AW), .W(MEMW)) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .re    (rd_en),
        .raddr (dadr),
        .rdata (rdata)
    );
endmodule
